// File: rtl/bgr_to_gray_pkg.sv
// Shared constants and FSM encoding for the BMP colour-to-grayscale converter.
package bmp_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int ADDR_WIDTH     = 20;
  localparam int BMP_TOTAL_SIZE = 786486;
  localparam int HEADER_SIZE    = 54;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    CALC,
    WR,
    DONE
  } state_e;

endpackage

// File: rtl/bgr_to_gray_luma.sv
// Combinational luma: gray = (77*R + 150*G + 29*B) >> 8, truncated, no rounding.
module gray_luma import bmp_pkg::*; #(
  parameter int BYTE_WIDTH = bmp_pkg::BYTE_WIDTH
) (
  input  logic [BYTE_WIDTH-1:0] b_i,
  input  logic [BYTE_WIDTH-1:0] g_i,
  input  logic [BYTE_WIDTH-1:0] r_i,
  output logic [BYTE_WIDTH-1:0] gray_o
);

  localparam int AccW = 2 * BYTE_WIDTH;

  logic [AccW-1:0] acc;

  // Coefficients sum to 256, so the accumulator cannot overflow.
  always_comb begin
    acc = AccW'(LUMA_R) * AccW'(r_i)
        + AccW'(LUMA_G) * AccW'(g_i)
        + AccW'(LUMA_B) * AccW'(b_i);
  end

  assign gray_o = acc[AccW-1:BYTE_WIDTH];

endmodule

// File: rtl/bgr_to_gray.sv
// Streams a 24-bit BMP from ROM to RAM: header copied verbatim, each BGR pixel
// replaced by three copies of its luma. RAM addresses are source address + 1.
module bgr_to_gray import bmp_pkg::*; #(
  parameter int BYTE_WIDTH     = bmp_pkg::BYTE_WIDTH,
  parameter int ADDR_WIDTH     = bmp_pkg::ADDR_WIDTH,
  parameter int BMP_TOTAL_SIZE = bmp_pkg::BMP_TOTAL_SIZE,
  parameter int HEADER_SIZE    = bmp_pkg::HEADER_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] ROM_Q,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_valid,
  output logic [BYTE_WIDTH-1:0] RAM_D,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LastHdrAddr = ADDR_WIDTH'(HEADER_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(BMP_TOTAL_SIZE);

  state_e                state_q, state_d;
  logic                  romValid_q, romValid_d;
  logic [ADDR_WIDTH-1:0] romAddr_q, romAddr_d;
  logic                  ramValid_q, ramValid_d;
  logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
  logic                  hdrWr_q, hdrWr_d;
  logic                  done_q, done_d;
  logic [1:0]            phase_q, phase_d;
  logic [BYTE_WIDTH-1:0] bByte_q, bByte_d;
  logic [BYTE_WIDTH-1:0] gByte_q, gByte_d;
  logic [BYTE_WIDTH-1:0] gray_q, gray_d;
  logic [BYTE_WIDTH-1:0] lumaGray;

  // R is not registered: it is on ROM_Q during CALC and feeds the luma directly.
  gray_luma #(.BYTE_WIDTH(BYTE_WIDTH)) u_luma (
    .b_i    (bByte_q),
    .g_i    (gByte_q),
    .r_i    (ROM_Q),
    .gray_o (lumaGray)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      romValid_q <= 1'b0;
      romAddr_q  <= '0;
      ramValid_q <= 1'b0;
      ramAddr_q  <= '0;
      hdrWr_q    <= 1'b0;
      done_q     <= 1'b0;
      phase_q    <= '0;
      bByte_q    <= '0;
      gByte_q    <= '0;
      gray_q     <= '0;
    end else begin
      state_q    <= state_d;
      romValid_q <= romValid_d;
      romAddr_q  <= romAddr_d;
      ramValid_q <= ramValid_d;
      ramAddr_q  <= ramAddr_d;
      hdrWr_q    <= hdrWr_d;
      done_q     <= done_d;
      phase_q    <= phase_d;
      bByte_q    <= bByte_d;
      gByte_q    <= gByte_d;
      gray_q     <= gray_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    romValid_d = 1'b0;
    romAddr_d  = romAddr_q;
    ramValid_d = 1'b0;
    ramAddr_d  = ramAddr_q;
    hdrWr_d    = 1'b0;
    done_d     = done_q;
    phase_d    = phase_q;
    bByte_d    = bByte_q;
    gByte_d    = gByte_q;
    gray_d     = gray_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = HDR;
          romValid_d = 1'b1;
          romAddr_d  = '0;
          ramAddr_d  = '0;
        end
      end

      // Each request is written back one cycle later; the trailing write
      // cycle (no request) hands over to the pixel loop.
      HDR: begin
        ramValid_d = romValid_q;
        hdrWr_d    = romValid_q;
        if (romValid_q) begin
          ramAddr_d  = romAddr_q + AddrOne;
          romAddr_d  = romAddr_q + AddrOne;
          romValid_d = (romAddr_q != LastHdrAddr);
        end else begin
          state_d    = RD;
          romValid_d = 1'b1;
          phase_d    = '0;
        end
      end

      RD: begin
        romAddr_d = romAddr_q + AddrOne;
        unique case (phase_q)
          2'd0: begin
            romValid_d = 1'b1;
            phase_d    = 2'd1;
          end
          2'd1: begin
            romValid_d = 1'b1;
            phase_d    = 2'd2;
            bByte_d    = ROM_Q;
          end
          default: begin
            gByte_d = ROM_Q;
            phase_d = '0;
            state_d = CALC;
          end
        endcase
      end

      CALC: begin
        gray_d     = lumaGray;
        ramValid_d = 1'b1;
        ramAddr_d  = ramAddr_q + AddrOne;
        state_d    = WR;
      end

      WR: begin
        if (phase_q != 2'd2) begin
          ramValid_d = 1'b1;
          ramAddr_d  = ramAddr_q + AddrOne;
          phase_d    = phase_q + 2'd1;
        end else begin
          phase_d = '0;
          if (ramAddr_q == LastAddr) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = RD;
            romValid_d = 1'b1;
          end
        end
      end

      DONE: done_d = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  assign ROM_valid = romValid_q;
  assign ROM_addr  = romAddr_q;
  assign RAM_valid = ramValid_q;
  assign RAM_addr  = ramAddr_q;
  assign done      = done_q;
  assign RAM_D     = !ramValid_q ? '0 : (hdrWr_q ? ROM_Q : gray_q);

endmodule

// File: tb/tb_bgr_to_gray.sv
// Bench for bgr_to_gray on a 4x2 image: the bench acts as ROM and RAM and
// checks the written file against a luma model computed from the source bytes.
module tb_bgr_to_gray;

  localparam int BW        = 8;
  localparam int AW        = 8;
  localparam int HDR_BYTES = 54;
  localparam int PIXELS    = 8;
  localparam int TOTAL     = HDR_BYTES + 3 * PIXELS;
  localparam int DONE_LAT  = 55 + PIXELS * 7 + 1;
  localparam int NUM_TBL   = 6;

  typedef struct {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] gray;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [BW-1:0] ROM_Q;
  logic          ROM_valid;
  logic [AW-1:0] ROM_addr;
  logic          RAM_valid;
  logic [BW-1:0] RAM_D;
  logic [AW-1:0] RAM_addr;
  logic          done;

  logic [BW-1:0] rom [0:TOTAL-1];
  logic [BW-1:0] ram [0:TOTAL];

  int cyc          = 0;
  int strobeCount  = 0;
  int postDoneActs = 0;
  int ram0Writes   = 0;
  int vectors      = 0;
  int miscompares  = 0;

  vec_t tbl [NUM_TBL];

  always #5 clk = ~clk;

  bgr_to_gray #(
    .BYTE_WIDTH     (BW),
    .ADDR_WIDTH     (AW),
    .BMP_TOTAL_SIZE (TOTAL),
    .HEADER_SIZE    (HDR_BYTES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ROM_Q     (ROM_Q),
    .ROM_valid (ROM_valid),
    .ROM_addr  (ROM_addr),
    .RAM_valid (RAM_valid),
    .RAM_D     (RAM_D),
    .RAM_addr  (RAM_addr),
    .done      (done)
  );

  // Registered ROM: holds when idle, resets to 0, out-of-range reads give 0.
  always @(posedge clk) begin
    if (!rst_n) ROM_Q <= '0;
    else if (ROM_valid) ROM_Q <= (int'(ROM_addr) < TOTAL) ? rom[ROM_addr] : '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ROM_valid || RAM_valid) strobeCount <= strobeCount + 1;
    if (done && (ROM_valid || RAM_valid)) postDoneActs <= postDoneActs + 1;
    if (RAM_valid) begin
      if (RAM_addr == '0) ram0Writes <= ram0Writes + 1;
      if (int'(RAM_addr) <= TOTAL) ram[RAM_addr] <= RAM_D;
    end
  end

  // Expected output byte at 1-based RAM address addr.
  function automatic int modelByte(input int addr);
    int idx;
    int base;
    if (addr <= HDR_BYTES) return int'(rom[addr-1]);
    idx  = (addr - HDR_BYTES - 1) / 3;
    base = HDR_BYTES + 3 * idx;
    return (77 * int'(rom[base+2]) + 150 * int'(rom[base+1]) + 29 * int'(rom[base])) / 256;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ROM_valid"}, int'(ROM_valid), 0);
    checkOutput({tag, "_ROM_addr"},  int'(ROM_addr),  0);
    checkOutput({tag, "_RAM_valid"}, int'(RAM_valid), 0);
    checkOutput({tag, "_RAM_addr"},  int'(RAM_addr),  0);
    checkOutput({tag, "_RAM_D"},     int'(RAM_D),     0);
    checkOutput({tag, "_done"},      int'(done),      0);
  endtask

  task automatic checkImage(input string tag);
    for (int a = 1; a <= TOTAL; a++)
      checkOutput($sformatf("%s_ram[%0d]", tag, a), int'(ram[a]), modelByte(a));
  endtask

  // Raise in_valid so it is sampled at the end of cycle startCyc.
  task automatic applyStimulus(input bit holdValid, output int startCyc);
    @(negedge clk);
    in_valid = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    if (!holdValid) in_valid = 1'b0;
  endtask

  task automatic waitDone(input int startCyc, output int firstWrLat, output int doneLat);
    firstWrLat = -1;
    doneLat    = -1;
    for (int i = 0; i < 400 && doneLat < 0; i++) begin
      @(negedge clk);
      if (RAM_valid && firstWrLat < 0) firstWrLat = cyc - startCyc;
      if (done) doneLat = cyc - startCyc;
    end
    if (doneLat < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 400 cycles");
    end
  endtask

  initial begin
    int s;
    int fw;
    int dl;
    int idleBase;

    tbl[0] = '{b: 8'd0,   g: 8'd0,   r: 8'd255, gray: 8'd76};
    tbl[1] = '{b: 8'd0,   g: 8'd255, r: 8'd0,   gray: 8'd149};
    tbl[2] = '{b: 8'd255, g: 8'd0,   r: 8'd0,   gray: 8'd28};
    tbl[3] = '{b: 8'd255, g: 8'd255, r: 8'd255, gray: 8'd255};
    tbl[4] = '{b: 8'd0,   g: 8'd0,   r: 8'd0,   gray: 8'd0};
    tbl[5] = '{b: 8'd10,  g: 8'd20,  r: 8'd30,  gray: 8'd21};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");

    rst_n    = 1'b1;
    idleBase = strobeCount;
    repeat (100) @(negedge clk);
    checkOutput("idle_strobes", strobeCount - idleBase, 0);
    checkOutput("idle_done", int'(done), 0);

    // Image A: random header, table pixels first, random pixels after.
    for (int k = 0; k < TOTAL; k++) rom[k] = 8'($urandom_range(0, 255));
    for (int i = 0; i < NUM_TBL; i++) begin
      rom[HDR_BYTES + 3*i]     = tbl[i].b;
      rom[HDR_BYTES + 3*i + 1] = tbl[i].g;
      rom[HDR_BYTES + 3*i + 2] = tbl[i].r;
    end

    applyStimulus(1'b0, s);
    waitDone(s, fw, dl);
    checkOutput("runA_first_write_latency", fw, 2);
    checkOutput("runA_done_latency", dl, DONE_LAT);
    for (int i = 0; i < NUM_TBL; i++)
      for (int j = 0; j < 3; j++)
        checkOutput($sformatf("tbl%0d_byte%0d", i, j),
                    int'(ram[HDR_BYTES + 1 + 3*i + j]), int'(tbl[i].gray));
    checkImage("runA");
    repeat (20) @(negedge clk);
    checkOutput("runA_post_done_activity", postDoneActs, 0);
    checkOutput("runA_done_sticky", int'(done), 1);

    // Image B: reset in the pixel phase, then restart from scratch.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < TOTAL; k++) rom[k] = 8'($urandom_range(0, 255));
    applyStimulus(1'b1, s);
    repeat (70) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checkResetOutputs("midrun_reset");
    rst_n = 1'b1;

    applyStimulus(1'b1, s);
    waitDone(s, fw, dl);
    in_valid = 1'b0;
    checkOutput("runB_first_write_latency", fw, 2);
    checkOutput("runB_done_latency", dl, DONE_LAT);
    checkImage("runB");
    repeat (20) @(negedge clk);
    checkOutput("runB_post_done_activity", postDoneActs, 0);
    checkOutput("ram0_writes", ram0Writes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
